vga_frame_capture: RTL
======================

Name: vga_frame_capture

Overview:
- VGA-timing receiver; the sink side of the 640x480@60 raster our display controller produces.
- Consumes sync pulses and 24-bit RGB on a pixel-clock enable, and recovers the raster position from the syncs.
- Converts pixels in a fixed window to 8-bit grayscale and writes them into the image frame-buffer SRAM through its write port.
- Captures one frame per start request and reports completion or sync loss.

Parameters:
- H_ACT0, 144: first active column after h_sync rising edge
- V_ACT0, 35: first active line after v_sync rising edge
- WIN_X0, 270: window left column (raster coordinates)
- WIN_Y0, 52: window top line (raster coordinates)
- WIN_W, 300: window width in pixels
- WIN_H, 300: window height in lines
- ADDR_W, 18: frame-buffer address width
- CNT_MAX, 1023: saturation value of the h/v counters (10-bit)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- pix_en  in  1  one-cycle strobe per pixel (25 MHz rate)
- h_sync  in  1  horizontal sync, active-high pulse
- v_sync  in  1  vertical sync, active-high pulse
- red  in  8  pixel red
- green  in  8  pixel green
- blue  in  8  pixel blue
- start  in  1  one-cycle capture request
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  one-cycle pulse when a frame completes
- err  out  1  sticky sync-loss flag; cleared by start
- wr_en  out  1  frame-buffer write strobe
- wr_addr  out  ADDR_W  frame-buffer address
- wr_data  out  8  grayscale pixel
- pix_count  out  17  writes in current/last capture

Behaviour:
- Reset (reset=0, async) drives busy, done, err, wr_en, wr_addr, wr_data and pix_count to 0, clears counters and edge registers, and forces state IDLE. Reset in mid-capture abandons the frame with no done and no err.
- All input sampling happens only on pix_en cycles. h_prev and v_prev register the syncs on each pix_en.
- h_cnt:
  - 0 on the pix_en where h_sync=1 and h_prev=0.
  - Otherwise +1, saturating at CNT_MAX.
- v_cnt, evaluated at h_sync rising edge:
  - If v_sync=1 and v_prev=0 on the same tick, v_cnt becomes 0 (v edge wins).
  - Otherwise v_cnt +1, saturating at CNT_MAX.
- In-window condition:
  - x = h_cnt - H_ACT0 - (WIN_X0 - H_ACT0); equivalently, in window when h_cnt is in [WIN_X0, WIN_X0+WIN_W-1].
  - v_cnt in [WIN_Y0, WIN_Y0+WIN_H-1], inclusive bounds.
- Address is computed incrementally, with no multiplier:
  - Reset to 0 at frame start.
  - +1 per in-window write.
  - Row-major order: address = (h_cnt-WIN_X0) + (v_cnt-WIN_Y0)*WIN_W, range 0..WIN_W*WIN_H-1.
- Gray conversion: gray = (R + 2G + B) >> 2, using a 10-bit sum and truncation.
- Latency: a pixel sampled on pix_en at cycle T produces wr_en=1 at T+1 for exactly one clk, with wr_addr/wr_data registered alongside. wr_en=0 otherwise.
- FSM:
  - IDLE: on start, go to ARMED; clear err and pix_count.
  - ARMED: on a v_sync rising edge (pix_en), go to CAPTURE; address=0.
  - CAPTURE: write in-window pixels.
    - Next v_sync rising edge: go to IDLE with done=1 for one clk.
    - h_cnt reaching CNT_MAX: go to IDLE with err=1, no done.
- start while busy is ignored. start coinciding with done is ignored.
- Counters run in every state so that position is valid when ARMED exits.
- A short frame (next vsync before WIN_H lines) still pulses done; pix_count shows the shortfall.
- pix_count increments with each wr_en and holds after the capture ends.

Optional Feature:
- Macro VGA_CAP_INVERT_EN.
- Defined: wr_data = 8'hFF - gray (negative image).
- Undefined: wr_data = gray.
- Timing is identical either way.

Decomposition:
- Package vga_cap_pkg:
  - state enum (IDLE, ARMED, CAPTURE).
  - Raster constants: H_TOTAL=800, V_TOTAL=525, HSYNC_W=96, VSYNC_W=2.
  - gray_t typedef (8-bit).
- Sub-module vga_sync_tracker holds the edge detect and the h_cnt/v_cnt logic; it is reusable by future receivers.

Test Plan:
- Full 800x525 frame with R=G=B=(x+y)[7:0], start before vsync:
  - Exactly 90000 wr_en.
  - First write addr 0 at raster (270,52); last write addr 89999 at (569,351).
  - done one clk after the next vsync edge; pix_count=90000.
- Constant pixels:
  - R=G=B=0x80 gives wr_data 0x80.
  - R=0xFF, G=B=0 gives 0x3F.
  - With VGA_CAP_INVERT_EN, 0x80 gives 0x7F.
- Pulse start in mid-CAPTURE: ignored; the frame completes normally with a single done.
- Stop h_sync during CAPTURE: after 1024 pix_en ticks err=1, busy=0, no done; the next start clears err.
- Assert reset at write 5000: all outputs 0 asynchronously. After release, start plus a frame gives a clean 90000-write capture.
- Frame truncated to 200 lines (vsync early): done pulses with pix_count=(200-52)*300=44400.

Source files
------------

// File: rtl/vga_cap_pkg.sv
// ---------------------------------------------------------------------------
// vga_cap_pkg
// Shared types and constants for the VGA frame-capture receiver.
//   state_t     : capture FSM states (IDLE, ARMED, CAPTURE)
//   H/V totals  : nominal 640x480@60 raster geometry of the source
//   CNT_W       : width of the raster position counters
//   gray_t      : 8-bit grayscale pixel
//   rgb_to_gray : (R + 2G + B) >> 2 with a 10-bit sum, truncating
// ---------------------------------------------------------------------------
package vga_cap_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;
    localparam int HSYNC_W = 96;
    localparam int VSYNC_W = 2;

    localparam int CNT_W = 10;

    typedef logic [7:0] gray_t;

    // Luma approximation: the 10-bit sum cannot overflow (max 1020).
    function automatic gray_t rgb_to_gray(input logic [7:0] r,
                                          input logic [7:0] g,
                                          input logic [7:0] b);
        logic [9:0] sum;
        sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
        return sum[9:2];
    endfunction

endpackage

// File: rtl/vga_frame_capture_if.sv
// ---------------------------------------------------------------------------
// vga_frame_capture_if
// Frame-buffer SRAM write port.
//   wr_en   : one-cycle write strobe
//   wr_addr : ADDR_W-bit word address
//   wr_data : 8-bit grayscale pixel
// master = capture block (drives), slave = SRAM side (receives).
// ---------------------------------------------------------------------------
interface vga_frame_capture_if #(
    parameter int ADDR_W = 18
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/vga_sync_tracker.sv
// ---------------------------------------------------------------------------
// vga_sync_tracker
// Recovers the raster position from h_sync/v_sync. All sampling is gated by
// pix_en. Column 0 is the pixel on which h_sync rises; line 0 is the line on
// whose h_sync rise v_sync also rises.
//   clk, reset (async, active-low), pix_en, h_sync, v_sync : inputs
//   v_rise : v_sync rising on the current tick (combinational, qualify
//            with pix_en)
//   h_pos, v_pos : position of the pixel presented on the current tick,
//                  i.e. the value the counters take when pix_en is high
// ---------------------------------------------------------------------------
module vga_sync_tracker
    import vga_cap_pkg::*;
#(
    parameter int CNT_MAX = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_en,
    input  logic             h_sync,
    input  logic             v_sync,
    output logic             v_rise,
    output logic [CNT_W-1:0] h_pos,
    output logic [CNT_W-1:0] v_pos
);

    localparam logic [CNT_W-1:0] MAX = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic             h_prev_reg;
    logic             v_prev_reg;
    logic [CNT_W-1:0] h_cnt_reg;
    logic [CNT_W-1:0] v_cnt_reg;
    logic             h_rise;

    assign h_rise = h_sync & ~h_prev_reg;
    assign v_rise = v_sync & ~v_prev_reg;

    // Next counter values double as the position of the pixel being sampled.
    always_comb begin
        h_pos = h_cnt_reg;
        v_pos = v_cnt_reg;
        if (h_rise) begin
            h_pos = '0;
            if (v_rise)
                v_pos = '0;
            else if (v_cnt_reg != MAX)
                v_pos = v_cnt_reg + ONE;
        end else if (h_cnt_reg != MAX) begin
            h_pos = h_cnt_reg + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_prev_reg <= 1'b0;
            v_prev_reg <= 1'b0;
            h_cnt_reg  <= '0;
            v_cnt_reg  <= '0;
        end else if (pix_en) begin
            h_prev_reg <= h_sync;
            v_prev_reg <= v_sync;
            h_cnt_reg  <= h_pos;
            v_cnt_reg  <= v_pos;
        end
    end

endmodule

// File: rtl/vga_frame_capture.sv
// ---------------------------------------------------------------------------
// vga_frame_capture
// VGA-timing receiver: captures one WIN_W x WIN_H grayscale window of a frame
// into the frame-buffer SRAM per start request.
//   clk, reset (async, active-low)
//   pix_en, h_sync, v_sync, red/green/blue : video input, sampled on pix_en
//   start     : one-cycle capture request (ignored while busy or on done)
//   busy      : ARMED or CAPTURE
//   done      : one-cycle pulse at the v_sync edge ending the captured frame
//   err       : sticky sync-loss flag (h counter saturated), cleared by start
//   pix_count : number of writes of the current/last capture
//   fb        : frame-buffer write port (master)
// Build option: define VGA_CAP_INVERT_EN to store the negative image
// (wr_data = 8'hFF - gray); timing is unchanged.
// ---------------------------------------------------------------------------
module vga_frame_capture
    import vga_cap_pkg::*;
#(
    parameter int H_ACT0  = 144,
    parameter int V_ACT0  = 35,
    parameter int WIN_X0  = 270,
    parameter int WIN_Y0  = 52,
    parameter int WIN_W   = 300,
    parameter int WIN_H   = 300,
    parameter int ADDR_W  = 18,
    parameter int CNT_MAX = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pix_en,
    input  logic                h_sync,
    input  logic                v_sync,
    input  logic [7:0]          red,
    input  logic [7:0]          green,
    input  logic [7:0]          blue,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [16:0]         pix_count,
    vga_frame_capture_if.master fb
);

    // Window offsets relative to the first active column/line.
    localparam int X_OFF = WIN_X0 - H_ACT0;
    localparam int Y_OFF = WIN_Y0 - V_ACT0;
    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(CNT_MAX);

    logic             v_rise;
    logic [CNT_W-1:0] h_pos;
    logic [CNT_W-1:0] v_pos;

    vga_sync_tracker #(
        .CNT_MAX (CNT_MAX)
    ) u_tracker (
        .clk    (clk),
        .reset  (reset),
        .pix_en (pix_en),
        .h_sync (h_sync),
        .v_sync (v_sync),
        .v_rise (v_rise),
        .h_pos  (h_pos),
        .v_pos  (v_pos)
    );

    // ---------------- window test ----------------
    int   x_act;
    int   y_act;
    logic in_win;

    always_comb begin
        x_act  = int'(h_pos) - H_ACT0;
        y_act  = int'(v_pos) - V_ACT0;
        in_win = (x_act >= X_OFF) && (x_act <= X_OFF + WIN_W - 1) &&
                 (y_act >= Y_OFF) && (y_act <= Y_OFF + WIN_H - 1);
    end

    // ---------------- gray conversion ----------------
    gray_t gray_raw;
    gray_t pix_gray;

    assign gray_raw = rgb_to_gray(red, green, blue);
`ifdef VGA_CAP_INVERT_EN
    assign pix_gray = 8'hFF - gray_raw;
`else
    assign pix_gray = gray_raw;
`endif

    // ---------------- FSM ----------------
    state_t state_reg;
    state_t state_next;
    logic   done_reg;
    logic   start_ok;
    logic   arm;
    logic   wr_fire;
    logic   frame_done;
    logic   sync_lost;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        start_ok   = 1'b0;
        arm        = 1'b0;
        wr_fire    = 1'b0;
        frame_done = 1'b0;
        sync_lost  = 1'b0;
        case (state_reg)
            IDLE: begin
                // done_reg high means the capture ended on the previous
                // edge; a start landing on that pulse is dropped.
                if (start && !done_reg) begin
                    state_next = ARMED;
                    start_ok   = 1'b1;
                end
            end
            ARMED: begin
                if (pix_en && v_rise) begin
                    state_next = CAPTURE;
                    arm        = 1'b1;
                end
            end
            CAPTURE: begin
                if (pix_en) begin
                    if (v_rise) begin
                        state_next = IDLE;
                        frame_done = 1'b1;
                    end else if (h_pos == H_MAX) begin
                        state_next = IDLE;
                        sync_lost  = 1'b1;
                    end else if (in_win) begin
                        wr_fire = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic              err_reg;
    logic              wr_en_reg;
    logic [ADDR_W-1:0] wr_addr_reg;
    logic [ADDR_W-1:0] addr_cnt_reg;
    gray_t             wr_data_reg;
    logic [16:0]       pix_count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            wr_en_reg     <= 1'b0;
            wr_addr_reg   <= '0;
            wr_data_reg   <= '0;
            addr_cnt_reg  <= '0;
            pix_count_reg <= '0;
        end else begin
            done_reg  <= frame_done;
            wr_en_reg <= wr_fire;
            if (start_ok) begin
                err_reg       <= 1'b0;
                pix_count_reg <= '0;
            end else if (sync_lost) begin
                err_reg <= 1'b1;
            end
            // Window is scanned in raster order, so a running count is the
            // row-major address without any multiply.
            if (arm)
                addr_cnt_reg <= '0;
            if (wr_fire) begin
                wr_addr_reg   <= addr_cnt_reg;
                wr_data_reg   <= pix_gray;
                addr_cnt_reg  <= addr_cnt_reg + ADDR_W'(1);
                pix_count_reg <= pix_count_reg + 17'd1;
            end
        end
    end

    assign busy       = (state_reg == ARMED) || (state_reg == CAPTURE);
    assign done       = done_reg;
    assign err        = err_reg;
    assign pix_count  = pix_count_reg;
    assign fb.wr_en   = wr_en_reg;
    assign fb.wr_addr = wr_addr_reg;
    assign fb.wr_data = wr_data_reg;

endmodule
